// File: rtl/boracore_mc_if.sv
// boracore_mc_if: instruction and data memory req/ack bus of the boracore_mc core
// Signals: imem_req/imem_addr/imem_ack/imem_rdata (instruction fetch),
//          dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/dmem_rdata (data access).
// Modports: master = core side, slave = memory side.
interface boracore_mc_if #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8,
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 14
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ack;
    logic [DATA_W-1:0]  dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/boracore_mc.sv
// boracore_mc: parametrised multi-cycle boracore CPU with req/ack instruction and data memories
// Ports: clk, rst (asynchronous, active high); bus (boracore_mc_if.master, imem/dmem handshakes);
//        pc, halted, illegal (status); dbg_sel -> dbg_val (combinational register read).
// Optional feature: define BORACORE_CARRY_EN for the carry flag and the JC opcode.
module boracore_mc #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4,
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8,
    localparam int RA_W    = $clog2(REG_CNT),
    localparam int INSTR_W = 4 + RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    boracore_mc_if.master      bus,
    output logic [IMEM_AW-1:0] pc,
    output logic               halted,
    output logic               illegal,
    input  logic [RA_W-1:0]    dbg_sel,
    output logic [DATA_W-1:0]  dbg_val
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    localparam logic [3:0] OP_LD = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_JZ = 4'd3,
                           OP_JNZ = 4'd4, OP_J = 4'd5, OP_ST = 4'd6, OP_LI = 4'd7,
                           OP_JC = 4'd8, OP_HALT = 4'd9;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d, pc_inc, target;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  r_q [REG_CNT];
    logic               z_q, z_d, c_q, c_d, ill_q, ill_d;
    logic               we, mem_op, done;
    logic [DATA_W-1:0]  wd, a, b, imm;
    logic [DATA_W:0]    sum, dif;
    logic [3:0]         op;
    logic [RA_W-1:0]    rd;

    function automatic logic [DATA_W-1:0] rd_reg(input logic [RA_W-1:0] i);
        return ({1'b0, i} < (RA_W+1)'(REG_CNT)) ? r_q[i] : '0;
    endfunction

    assign op     = ir_q[INSTR_W-1 -: 4];
    assign rd     = ir_q[DATA_W +: RA_W];
    assign imm    = ir_q[DATA_W-1:0];
    assign a      = rd_reg(rd);
    assign b      = rd_reg(imm[RA_W-1:0]);
    assign sum    = {1'b0, a} + {1'b0, b};
    assign dif    = {1'b0, a} - {1'b0, b};
    assign pc_inc = pc_q + 1'b1;
    assign target = imm[IMEM_AW-1:0];
    assign mem_op = (op == OP_LD) || (op == OP_ST);
    // Memory ops complete only on ack; everything else finishes in its first EXEC cycle.
    assign done   = !mem_op || bus.dmem_ack;

    // Requests are gated by rst so a pending access is dropped the moment reset asserts.
    assign bus.imem_req   = !rst && (state_q == FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = !rst && (state_q == EXEC) && mem_op;
    assign bus.dmem_we    = bus.dmem_req && (op == OP_ST);
    assign bus.dmem_addr  = imm[DMEM_AW-1:0];
    assign bus.dmem_wdata = a;

    assign pc      = pc_q;
    assign halted  = (state_q == HALT);
    assign illegal = ill_q;
    assign dbg_val = rd_reg(dbg_sel);

`ifdef BORACORE_CARRY_EN
    localparam bit JC_EN = 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) c_q <= 1'b0;
        else c_q <= c_d;
    end
`else
    localparam bit JC_EN = 1'b0;
    logic unused_c;
    assign c_q      = 1'b0;
    assign unused_c = c_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        c_d     = c_q;
        ill_d   = ill_q;
        we      = 1'b0;
        wd      = '0;
        if (state_q == FETCH && bus.imem_ack) begin
            ir_d    = bus.imem_rdata;
            state_d = EXEC;
        end
        if (state_q == EXEC && done) begin
            state_d = FETCH;
            pc_d    = pc_inc;
            case (op)
                OP_LD:   begin we = 1'b1; wd = bus.dmem_rdata; end
                OP_ADD:  begin we = 1'b1; wd = sum[DATA_W-1:0]; c_d = sum[DATA_W]; end
                OP_SUB:  begin we = 1'b1; wd = dif[DATA_W-1:0]; c_d = dif[DATA_W]; end
                OP_LI:   begin we = 1'b1; wd = imm; end
                OP_JZ:   pc_d = z_q ? target : pc_inc;
                OP_JNZ:  pc_d = z_q ? pc_inc : target;
                OP_J:    pc_d = target;
                OP_ST:   ;
                OP_JC:   begin
                    pc_d    = JC_EN ? (c_q ? target : pc_inc) : pc_q;
                    ill_d   = !JC_EN;
                    state_d = JC_EN ? FETCH : HALT;
                end
                OP_HALT: begin pc_d = pc_q; state_d = HALT; end
                default: begin pc_d = pc_q; ill_d = 1'b1; state_d = HALT; end
            endcase
            z_d = we ? (wd == '0) : z_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            ill_q   <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            ill_q   <= ill_d;
            if (we && ({1'b0, rd} < (RA_W+1)'(REG_CNT))) r_q[rd] <= wd;
        end
    end
endmodule

// File: tb/tb_boracore_mc.sv
// tb_boracore_mc: directed self-checking bench for boracore_mc with wait-stated memory models
module tb_boracore_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_val, pc;
    logic        halted, illegal;
    logic [13:0] imem [256];
    logic [7:0]  dmem [256];
    int          iw = 0, dw = 0, icnt = 0, dcnt = 0;
    int          wcount = 0;
    logic [7:0]  waddr = '0, wdata = '0;
    int          n_cmp = 0, n_bad = 0;

    boracore_mc_if #(.IMEM_AW(8), .DMEM_AW(8), .DATA_W(8), .INSTR_W(14)) bus ();

    boracore_mc dut (
        .clk(clk), .rst(rst), .bus(bus), .pc(pc), .halted(halted),
        .illegal(illegal), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    assign bus.imem_ack   = bus.imem_req && (icnt >= iw);
    assign bus.imem_rdata = imem[bus.imem_addr];
    assign bus.dmem_ack   = bus.dmem_req && (dcnt >= dw);
    assign bus.dmem_rdata = dmem[bus.dmem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
            dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
            if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
                wcount <= wcount + 1;
                waddr  <= bus.dmem_addr;
                wdata  <= bus.dmem_wdata;
            end
        end
    end

    function automatic logic [13:0] ins(input int op, input int rd, input int imm);
        return {4'(op), 2'(rd), 8'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_rst();
        @(negedge clk);
        rst = 1'b1;
        iw = 0;
        dw = 0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = ins(9, 0, 0);
            dmem[i] = 8'(i ^ 8'h5A);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] reg_val(input int i);
        return 8'(i);
    endfunction

    task automatic peek(input int r, output logic [7:0] v);
        dbg_sel = 2'(r);
        #1 v = dbg_val;
    endtask

    logic [7:0] v;
    int req_cycles;

    initial begin
        // Reset state
        hold_rst();
        @(negedge clk);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_dmem_req", bus.dmem_req, 0);
        check("rst_dmem_we", bus.dmem_we, 0);
        check("rst_dmem_addr", bus.dmem_addr, 0);
        check("rst_dmem_wdata", bus.dmem_wdata, 0);
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);

        // Countdown loop with zero-wait memory
        imem[0] = ins(7, 2, 3);
        imem[1] = ins(7, 1, 1);
        imem[2] = ins(2, 2, 1);
        imem[3] = ins(4, 0, 2);
        imem[4] = ins(5, 0, 4);
        release_rst();
        #1 check("loop_req_after_rst", bus.imem_req, 1);
        step(4);
        check("loop_pc_2instr", pc, 2);
        step(11);
        check("loop_pc_7instr", pc, 3);
        step(1);
        check("loop_pc_exit", pc, 4);
        step(10);
        check("loop_pc_sticks", pc, 4);
        peek(2, v);
        check("loop_r2", v, 0);
        peek(1, v);
        check("loop_r1", v, 1);
        check("loop_z", dut.z_q, 1);
        check("loop_halted", halted, 0);

        // LD with three wait cycles on the data port
        hold_rst();
        dw = 3;
        imem[0] = ins(0, 0, 5);
        release_rst();
        step(1);
        req_cycles = 0;
        for (int i = 0; i < 8 && bus.dmem_req; i++) begin
            req_cycles++;
            check("ld_we", bus.dmem_we, 0);
            check("ld_addr", bus.dmem_addr, 5);
            peek(0, v);
            check("ld_r0_pending", v, 0);
            step(1);
        end
        check("ld_req_cycles", req_cycles, 4);
        peek(0, v);
        check("ld_r0", v, 8'h5F);
        check("ld_pc", pc, 1);

        // ST after LI
        hold_rst();
        imem[0] = ins(7, 0, 8'hAB);
        imem[1] = ins(6, 0, 9);
        release_rst();
        step(3);
        check("st_req", bus.dmem_req, 1);
        check("st_we", bus.dmem_we, 1);
        check("st_addr", bus.dmem_addr, 9);
        check("st_wdata", bus.dmem_wdata, 8'hAB);
        step(7);
        check("st_count", wcount, 1);
        check("st_waddr", waddr, 9);
        check("st_wdata_seen", wdata, 8'hAB);
        check("halt_halted", halted, 1);
        check("halt_illegal", illegal, 0);
        check("halt_imem_req", bus.imem_req, 0);
        check("halt_dmem_req", bus.dmem_req, 0);
        check("halt_pc", pc, 2);

        // ADD overflow, then JC
        hold_rst();
        imem[0] = ins(7, 0, 8'hFF);
        imem[1] = ins(7, 1, 1);
        imem[2] = ins(1, 0, 1);
        imem[3] = ins(8, 0, 8'h10);
        imem[8'h10] = ins(5, 0, 8'h10);
        release_rst();
        step(6);
        peek(0, v);
        check("add_r0", v, 0);
        check("add_z", dut.z_q, 1);
        check("add_pc", pc, 3);
        step(2);
`ifdef BORACORE_CARRY_EN
        check("add_c", dut.c_q, 1);
        check("jc_pc", pc, 8'h10);
        check("jc_illegal", illegal, 0);
        check("jc_halted", halted, 0);
`else
        check("jc_pc", pc, 3);
        check("jc_illegal", illegal, 1);
        check("jc_halted", halted, 1);
`endif

        // pc wrap from 0xFF
        hold_rst();
        imem[0] = ins(5, 0, 8'hFF);
        imem[8'hFF] = ins(7, 3, 8'h42);
        release_rst();
        step(2);
        check("wrap_pc_ff", pc, 8'hFF);
        step(2);
        check("wrap_pc_0", pc, 0);
        peek(3, v);
        check("wrap_r3", v, 8'h42);

        // Undefined opcode traps
        hold_rst();
        imem[0] = ins(12, 0, 0);
        release_rst();
        step(2);
        check("ill_illegal", illegal, 1);
        check("ill_halted", halted, 1);
        check("ill_pc", pc, 0);
        step(3);
        check("ill_imem_req", bus.imem_req, 0);

        // Reset during a pending fetch wait
        hold_rst();
        imem[0] = ins(7, 1, 7);
        release_rst();
        step(2);
        check("rw_pc_before", pc, 1);
        iw = 5;
        step(2);
        check("rw_req_pending", bus.imem_req, 1);
        rst = 1'b1;
        #1 check("rw_req_drop", bus.imem_req, 0);
        check("rw_pc_rst", pc, 0);
        peek(1, v);
        check("rw_r1_rst", v, 0);
        iw = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rw_req_restart", bus.imem_req, 1);
        check("rw_addr_restart", bus.imem_addr, 0);
        step(2);
        check("rw_pc_after", pc, 1);
        peek(1, v);
        check("rw_r1_after", v, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
